// File: rtl/acc_datapath.sv
// Element-wise adder datapath: S[i] = A[i] + B[i] over a sync SRAM port, driven by controller strobes.
// Optional ACC_SAT_ADD_EN: signed-saturating add instead of wrapping add.
module acc_datapath #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned IDX_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       to_hw_data,
    input  logic              load_len,
    input  logic              load_addr_a,
    input  logic              load_addr_b,
    input  logic              load_addr_s,
    input  logic              load_a,
    input  logic              load_b,
    input  logic              load_s,
    input  logic [1:0]        addrmux_sel,
    input  logic              addrinput_sel,
    input  logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ce,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       len_q,
    output logic [IDX_W-1:0]  elem_idx,
    output logic [DATA_W-1:0] s_q,
    output logic              ovf_flag
);

    localparam logic [DATA_W-1:0] SatMax = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SatMin = {1'b1, {(DATA_W-1){1'b0}}};

    logic [ADDR_W-1:0] base_a_q, base_b_q, base_s_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic [ADDR_W-1:0] base_sel;
    logic [ADDR_W-1:0] idx_ext;
    logic [DATA_W-1:0] sum_raw;
    logic [DATA_W-1:0] sum_d;
    logic              ovf;
    logic              port_write;

    always_comb begin
        case (addrmux_sel)
            2'd1:    base_sel = base_b_q;
            2'd2:    base_sel = base_s_q;
            default: base_sel = base_a_q;
        endcase
        idx_ext  = ADDR_W'(elem_idx);
        mem_addr = base_sel + idx_ext;
    end

    // Port strobes are forced low while reset is held so the SRAM sees no access.
    assign mem_ce     = addrinput_sel & ~reset;
    assign mem_we     = addrinput_sel & mem_write & ~reset;
    assign mem_wdata  = s_q;
    assign port_write = addrinput_sel & mem_write;

    always_comb begin
        sum_raw = a_q + b_q;
        ovf     = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (sum_raw[DATA_W-1] != a_q[DATA_W-1]);
`ifdef ACC_SAT_ADD_EN
        if (ovf) begin
            sum_d = a_q[DATA_W-1] ? SatMin : SatMax;
        end else begin
            sum_d = sum_raw;
        end
`else
        sum_d = sum_raw;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q    <= '0;
            base_a_q <= '0;
            base_b_q <= '0;
            base_s_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
        end else begin
            if (load_len)    len_q    <= to_hw_data;
            if (load_addr_a) base_a_q <= to_hw_data[ADDR_W-1:0];
            if (load_addr_b) base_b_q <= to_hw_data[ADDR_W-1:0];
            if (load_addr_s) base_s_q <= to_hw_data[ADDR_W-1:0];
            if (load_a)      a_q      <= mem_rdata;
            if (load_b)      b_q      <= mem_rdata;
            if (load_s)      s_q      <= sum_d;
        end
    end

    // load_len takes priority over an index advance or overflow in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            elem_idx <= '0;
            ovf_flag <= 1'b0;
        end else if (load_len) begin
            elem_idx <= '0;
            ovf_flag <= 1'b0;
        end else begin
            if (port_write)   elem_idx <= elem_idx + IDX_W'(1);
            if (load_s && ovf) ovf_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_acc_datapath.sv
// Self-checking bench for acc_datapath with a behavioural 1-cycle-latency sync SRAM.
module tb_acc_datapath;

    logic        clk;
    logic        reset;
    logic [31:0] to_hw_data;
    logic        load_len, load_addr_a, load_addr_b, load_addr_s;
    logic        load_a, load_b, load_s;
    logic [1:0]  addrmux_sel;
    logic        addrinput_sel, mem_write;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ce, mem_we;
    logic [31:0] mem_rdata;
    logic [31:0] len_q;
    logic [15:0] elem_idx;
    logic [31:0] s_q;
    logic        ovf_flag;

    int checks = 0;
    int errors = 0;

    logic [31:0] sram [0:65535];
    logic        poke_en;
    logic [15:0] poke_addr;
    logic [31:0] poke_data;

    acc_datapath #(.DATA_W(32), .ADDR_W(16), .IDX_W(16)) dut (
        .clk(clk), .reset(reset), .to_hw_data(to_hw_data),
        .load_len(load_len), .load_addr_a(load_addr_a), .load_addr_b(load_addr_b),
        .load_addr_s(load_addr_s), .load_a(load_a), .load_b(load_b), .load_s(load_s),
        .addrmux_sel(addrmux_sel), .addrinput_sel(addrinput_sel), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ce(mem_ce), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .len_q(len_q), .elem_idx(elem_idx), .s_q(s_q),
        .ovf_flag(ovf_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (poke_en) begin
            sram[poke_addr] <= poke_data;
        end else if (mem_ce) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata      <= sram[mem_addr];
        end
    end

    typedef struct {
        logic [1:0]  sel;
        logic        ais;
        logic        mw;
        logic [15:0] addr;
        logic        ce;
        logic        we;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        load_len = 0; load_addr_a = 0; load_addr_b = 0; load_addr_s = 0;
        load_a = 0; load_b = 0; load_s = 0;
        addrmux_sel = 2'd0; addrinput_sel = 0; mem_write = 0;
    endtask

    task automatic poke(input logic [15:0] addr, input logic [31:0] data);
        poke_en = 1; poke_addr = addr; poke_data = data;
        step();
        poke_en = 0;
    endtask

    task automatic write_cycle();
        idle(); addrmux_sel = 2'd2; addrinput_sel = 1; mem_write = 1;
        step();
        idle();
    endtask

    // Expects base_a=0x10, base_b=0x20 and elem_idx==idx.
    task automatic run_add(input logic [31:0] a, input logic [31:0] b, input logic [15:0] idx);
        poke(16'h0010 + idx, a);
        poke(16'h0020 + idx, b);
        idle(); addrmux_sel = 2'd0; addrinput_sel = 1; step();
        idle(); load_a = 1; addrmux_sel = 2'd1; addrinput_sel = 1; step();
        idle(); load_b = 1; step();
        idle(); load_s = 1; step();
        idle();
    endtask

    task automatic load_reg(input int which, input logic [31:0] data);
        idle(); to_hw_data = data;
        case (which)
            0: load_len = 1;
            1: load_addr_a = 1;
            2: load_addr_b = 1;
            default: load_addr_s = 1;
        endcase
        step();
        idle();
    endtask

    logic [31:0] a_in [4];
    logic [31:0] b_in [4];
    logic [31:0] exp_pos, exp_neg;

    initial begin
        reset = 0; to_hw_data = '0; poke_en = 0; poke_addr = '0; poke_data = '0;
        idle();
        vecs[0] = '{2'd0, 1'b1, 1'b0, 16'h0010, 1'b1, 1'b0};
        vecs[1] = '{2'd1, 1'b1, 1'b0, 16'h0020, 1'b1, 1'b0};
        vecs[2] = '{2'd2, 1'b1, 1'b1, 16'h0030, 1'b1, 1'b1};
        vecs[3] = '{2'd3, 1'b1, 1'b0, 16'h0010, 1'b1, 1'b0};
        vecs[4] = '{2'd2, 1'b0, 1'b1, 16'h0030, 1'b0, 1'b0};
        vecs[5] = '{2'd0, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0};
        a_in = '{32'd1, 32'd2, 32'd3, 32'd4};
        b_in = '{32'd10, 32'd20, 32'd30, 32'd40};
`ifdef ACC_SAT_ADD_EN
        exp_pos = 32'h7FFF_FFFF;
        exp_neg = 32'h8000_0000;
`else
        exp_pos = 32'h8000_0000;
        exp_neg = 32'h7FFF_FFFF;
`endif

        #1 reset = 1;
        #1;
        check("rst_len", len_q, 0);
        check("rst_idx", {16'd0, elem_idx}, 0);
        check("rst_s", s_q, 0);
        check("rst_ovf", {31'd0, ovf_flag}, 0);
        #1 reset = 0;
        step();

        load_reg(0, 32'd4);
        check("len_capture", len_q, 4);
        load_reg(1, 32'h0010);
        load_reg(2, 32'h0020);
        load_reg(3, 32'h0030);

        for (int i = 0; i < 6; i++) begin
            addrmux_sel = vecs[i].sel; addrinput_sel = vecs[i].ais; mem_write = vecs[i].mw;
            #1;
            check($sformatf("vec%0d_addr", i), {16'd0, mem_addr}, {16'd0, vecs[i].addr});
            check($sformatf("vec%0d_ce", i), {31'd0, mem_ce}, {31'd0, vecs[i].ce});
            check($sformatf("vec%0d_we", i), {31'd0, mem_we}, {31'd0, vecs[i].we});
            idle();
        end

        for (int i = 0; i < 4; i++) begin
            run_add(a_in[i], b_in[i], 16'(i));
            check($sformatf("sum%0d", i), s_q, a_in[i] + b_in[i]);
            write_cycle();
        end
        for (int i = 0; i < 4; i++)
            check($sformatf("sram_s%0d", i), sram[16'h0030 + 16'(i)], a_in[i] + b_in[i]);
        check("idx_after_run", {16'd0, elem_idx}, 4);
        check("ovf_after_run", {31'd0, ovf_flag}, 0);

        // Address wrap: base_s=0xFFFF, elem_idx=1.
        load_reg(3, 32'h0000_FFFF);
        load_reg(0, 32'd4);
        write_cycle();
        addrmux_sel = 2'd2; #1;
        check("addr_wrap", {16'd0, mem_addr}, 0);
        idle();

        run_add(32'h7FFF_FFFF, 32'd1, 16'd1);
        check("pos_ovf_sum", s_q, exp_pos);
        check("pos_ovf_flag", {31'd0, ovf_flag}, 1);
        run_add(32'd1, 32'd2, 16'd1);
        check("ovf_sticky_sum", s_q, 3);
        check("ovf_sticky", {31'd0, ovf_flag}, 1);
        load_reg(0, 32'd4);
        check("ovf_cleared", {31'd0, ovf_flag}, 0);
        run_add(32'h8000_0000, 32'hFFFF_FFFF, 16'd0);
        check("neg_ovf_sum", s_q, exp_neg);
        check("neg_ovf_flag", {31'd0, ovf_flag}, 1);

        for (int i = 0; i < 7; i++) write_cycle();
        check("idx_seven", {16'd0, elem_idx}, 7);
        idle(); to_hw_data = 32'd9; load_len = 1; mem_write = 1; addrinput_sel = 1;
        step();
        idle();
        check("clear_wins_idx", {16'd0, elem_idx}, 0);
        check("clear_wins_ovf", {31'd0, ovf_flag}, 0);
        check("clear_wins_len", len_q, 9);

        write_cycle();
        addrinput_sel = 0; mem_write = 1; #1;
        check("gated_we", {31'd0, mem_we}, 0);
        step();
        idle();
        check("gated_idx", {16'd0, elem_idx}, 1);

        idle(); to_hw_data = 32'h0000_1234;
        load_addr_a = 1; load_addr_b = 1; load_addr_s = 1;
        step();
        idle();
        for (int s = 0; s < 3; s++) begin
            addrmux_sel = 2'(s); #1;
            check($sformatf("multi_base%0d", s), {16'd0, mem_addr}, 32'h0000_1235);
        end
        idle();

        load_reg(1, 32'h0010);
        load_reg(2, 32'h0020);
        write_cycle();
        write_cycle();
        run_add(32'd2, 32'd3, 16'd3);
        check("pre_rst_s", s_q, 5);
        check("pre_rst_idx", {16'd0, elem_idx}, 3);
        addrinput_sel = 1; mem_write = 1; addrmux_sel = 2'd2;
        #1 reset = 1;
        #1;
        check("mid_rst_s", s_q, 0);
        check("mid_rst_idx", {16'd0, elem_idx}, 0);
        check("mid_rst_len", len_q, 0);
        check("mid_rst_ovf", {31'd0, ovf_flag}, 0);
        check("mid_rst_ce", {31'd0, mem_ce}, 0);
        check("mid_rst_we", {31'd0, mem_we}, 0);
        check("mid_rst_addr", {16'd0, mem_addr}, 0);
        idle();
        #1 reset = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
